// File: rtl/i_cache_if.sv
// Fetch-side and memory-side signal bundle for the direct-mapped instruction cache.
// The cache uses the slave modport; the CPU/memory environment uses master.
interface i_cache_if;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ_EN;
    logic [27:0]  MEM_READ_ADDR;
    logic         MEM_BUSYWAIT;
    logic [127:0] MEM_READ_DATA;

    modport slave (
        input  PC,
        input  MEM_BUSYWAIT,
        input  MEM_READ_DATA,
        output INSTRUCTION,
        output BUSYWAIT,
        output MEM_READ_EN,
        output MEM_READ_ADDR
    );

    modport master (
        output PC,
        output MEM_BUSYWAIT,
        output MEM_READ_DATA,
        input  INSTRUCTION,
        input  BUSYWAIT,
        input  MEM_READ_EN,
        input  MEM_READ_ADDR
    );
endinterface

// File: rtl/i_cache.sv
// Direct-mapped instruction cache: zero-latency hits, one 128-bit block read per miss.
// The line fill always uses the captured miss address, never the live PC.
module i_cache #(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic     CLK,
    input  logic     RESET,
    i_cache_if.slave bus
);
    localparam int unsigned TAG_BITS  = 28 - INDEX_BITS;
    localparam int unsigned NUM_LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
    logic [127:0]          data_q [NUM_LINES];
    logic [27:0]           miss_addr_q, miss_addr_d;
    logic [127:0]          fill_q, fill_d;
    logic                  line_we;

    logic [1:0]            pc_offset;
    logic [INDEX_BITS-1:0] pc_index, fill_index;
    logic [TAG_BITS-1:0]   pc_tag, fill_tag;
    logic                  hit;

    assign pc_offset  = bus.PC[3:2];
    assign pc_index   = bus.PC[4 +: INDEX_BITS];
    assign pc_tag     = bus.PC[31 -: TAG_BITS];
    assign fill_index = miss_addr_q[INDEX_BITS-1:0];
    assign fill_tag   = miss_addr_q[27 -: TAG_BITS];

    assign hit             = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign bus.INSTRUCTION = data_q[pc_index][{pc_offset, 5'd0} +: 32];

    // Next-state and Moore outputs; BUSYWAIT is the only hit-dependent output
    always_comb begin
        state_d           = state_q;
        miss_addr_d       = miss_addr_q;
        fill_d            = fill_q;
        line_we           = 1'b0;
        bus.BUSYWAIT      = 1'b1;
        bus.MEM_READ_EN   = 1'b0;
        bus.MEM_READ_ADDR = 28'd0;
        unique case (state_q)
            IDLE: begin
                bus.BUSYWAIT = !hit;
                if (!hit) begin
                    miss_addr_d = bus.PC[31:4];
                    state_d     = MEM_READ;
                end
            end
            MEM_READ: begin
                bus.MEM_READ_EN   = 1'b1;
                bus.MEM_READ_ADDR = miss_addr_q;
                if (!bus.MEM_BUSYWAIT) begin
                    fill_d  = bus.MEM_READ_DATA;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                line_we = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            miss_addr_q <= 28'd0;
            fill_q      <= 128'd0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            fill_q      <= fill_d;
        end
    end

    // Line storage; cleared on reset so INSTRUCTION reads zero before any fill
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
            for (int i = 0; i < int'(NUM_LINES); i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (line_we) begin
            valid_q[fill_index] <= 1'b1;
            tag_q[fill_index]   <= fill_tag;
            data_q[fill_index]  <= fill_q;
        end
    end
endmodule

// File: tb/tb_i_cache.sv
// Randomized scoreboard bench for i_cache: a behavioural cache/memory model
// predicts each fetch's instruction, stall length and block-request count.
module tb_i_cache;
    logic CLK;
    logic RESET;

    i_cache_if bus ();

    i_cache #(.INDEX_BITS(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        int          stall;
        int          rises;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          issued   = 0;
    int          served   = 0;
    int          rises    = 0;
    int          lat      = 0;
    logic [27:0] exp_addr = 28'd0;
    logic [31:0] seed;

    // Model of the cache contents: which block address each line holds
    bit          m_valid [8];
    logic [27:0] m_blk   [8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a >> 2) * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] b);
        logic [127:0] d;
        for (int k = 0; k < 4; k++)
            d[32*k +: 32] = mem_word({b, 4'b0000} + 32'(4 * k));
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_now();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    // Issue one fetch (optionally releasing reset at the same moment) and wait for it to be served
    task automatic fetch(input logic [31:0] pc, input int l, input bit release_rst);
        exp_t        e;
        logic [27:0] blk;
        int          idx;
        bit          m_hit;
        int          t;
        @(posedge CLK);
        #1;
        blk      = pc[31:4];
        idx      = int'(blk % 8);
        m_hit    = m_valid[idx] && (m_blk[idx] == blk);
        lat      = l;
        exp_addr = blk;
        e.instr  = mem_word(pc);
        e.stall  = m_hit ? 0 : l + 3;
        e.rises  = rises + (m_hit ? 0 : 1);
        m_valid[idx] = 1'b1;
        m_blk[idx]   = blk;
        exp_q.push_back(e);
        issued++;
        bus.PC = pc;
        if (release_rst) RESET = 1'b1;
        t = 0;
        while (served != issued && t < 400) begin
            @(negedge CLK);
            #1;
            t++;
        end
        if (served != issued) begin
            check("serve_timeout", 32'(served), 32'(issued));
            finish_now();
        end
    endtask

    // Scoreboard monitor: counts stall cycles and pops an expectation when BUSYWAIT drops
    initial begin
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge CLK);
            if (RESET && exp_q.size() > 0) begin
                if (bus.BUSYWAIT) begin
                    busy_cnt++;
                end else begin
                    e = exp_q.pop_front();
                    check("instruction", bus.INSTRUCTION, e.instr);
                    check("stall_cycles", 32'(busy_cnt), 32'(e.stall));
                    check("block_requests", 32'(rises), 32'(e.rises));
                    busy_cnt = 0;
                    served++;
                end
            end else begin
                busy_cnt = 0;
            end
        end
    end

    // Memory responder: holds MEM_BUSYWAIT high for 'lat' cycles with junk data, then returns the block
    initial begin
        int en_cnt;
        int cur_lat;
        bit prev_en;
        bit acc;
        en_cnt  = 0;
        cur_lat = 0;
        prev_en = 1'b0;
        acc     = 1'b0;
        bus.MEM_BUSYWAIT  = 1'b0;
        bus.MEM_READ_DATA = '0;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                en_cnt  = 0;
                prev_en = 1'b0;
                acc     = 1'b0;
                bus.MEM_BUSYWAIT = 1'b0;
            end else begin
                if (acc) begin
                    check("update_read_en", 32'(bus.MEM_READ_EN), 32'd0);
                    check("update_busywait", 32'(bus.BUSYWAIT), 32'd1);
                    acc = 1'b0;
                end
                if (bus.MEM_READ_EN) begin
                    if (!prev_en) begin
                        rises++;
                        cur_lat = lat;
                    end
                    check("read_addr", 32'(bus.MEM_READ_ADDR), 32'(exp_addr));
                    if (en_cnt < cur_lat) begin
                        bus.MEM_BUSYWAIT  = 1'b1;
                        bus.MEM_READ_DATA = {$urandom, $urandom, $urandom, $urandom};
                    end else begin
                        bus.MEM_BUSYWAIT  = 1'b0;
                        bus.MEM_READ_DATA = mem_block(bus.MEM_READ_ADDR);
                        acc = 1'b1;
                    end
                    en_cnt++;
                end else begin
                    if (prev_en) check("read_en_cycles", 32'(en_cnt), 32'(cur_lat + 1));
                    en_cnt = 0;
                    bus.MEM_BUSYWAIT = 1'b0;
                end
                prev_en = bus.MEM_READ_EN;
            end
        end
    end

    initial begin
        #1_000_000;
        check("global_timeout", 32'(served), 32'(issued + 1));
        finish_now();
    end

    // Stimulus
    initial begin
        int r0;
        int n;
        int t;
        seed   = $urandom;
        RESET  = 1'b0;
        bus.PC = 32'h0;
        model_clear();
        repeat (3) @(posedge CLK);
        #1;
        check("reset_read_en", 32'(bus.MEM_READ_EN), 32'd0);
        check("reset_read_addr", 32'(bus.MEM_READ_ADDR), 32'd0);
        check("reset_instruction", bus.INSTRUCTION, 32'd0);
        check("reset_busywait", 32'(bus.BUSYWAIT), 32'd1);

        // Cold miss, same-block hits, then a conflicting tag on index 0 and back
        fetch(32'h0000_0000, 3, 1'b1);
        fetch(32'h0000_0004, 0, 1'b0);
        fetch(32'h0000_0008, 0, 1'b0);
        fetch(32'h0000_000C, 0, 1'b0);
        fetch(32'h0000_0080, 2, 1'b0);
        fetch(32'h0000_0000, 1, 1'b0);

        // Long memory latency
        fetch(32'h0000_0104, 16, 1'b0);
        fetch(32'h0000_0108, 0, 1'b0);

        // Reset five cycles into MEM_READ; the line must stay invalid
        @(posedge CLK);
        #1;
        lat      = 20;
        exp_addr = 28'h20;
        bus.PC   = 32'h0000_0200;
        n = 0;
        t = 0;
        while (n < 5 && t < 100) begin
            @(posedge CLK);
            #1;
            if (bus.MEM_READ_EN) n++;
            t++;
        end
        check("mid_miss_reached", 32'(n), 32'd5);
        RESET = 1'b0;
        model_clear();
        #1;
        check("abort_read_en", 32'(bus.MEM_READ_EN), 32'd0);
        check("abort_busywait", 32'(bus.BUSYWAIT), 32'd1);
        fetch(32'h0000_0200, 2, 1'b1);

        // Sweep all 32 words of the first 8 blocks twice
        r0 = rises;
        for (int a = 0; a < 32; a++)
            fetch(32'(a * 4), int'($urandom_range(0, 3)), 1'b0);
        r0 = rises - r0;
        r0 = r0 + 0;
        check("sweep1_misses", 32'(r0), 32'd8);
        r0 = rises;
        for (int a = 0; a < 32; a++)
            fetch(32'(a * 4), 0, 1'b0);
        check("sweep2_misses", 32'(rises - r0), 32'd0);

        // Random fetches over four tags per index
        for (int i = 0; i < 200; i++)
            fetch($urandom & 32'h0000_01FC, int'($urandom_range(0, 4)), 1'b0);

        repeat (3) @(posedge CLK);
        finish_now();
    end
endmodule
